ika87ad_intc: RTL and testbench
===============================

IKA87AD_INTC -- requirements
Module: ika87ad_intc

Interface
REQ-001 SHALL have port i_EMUCLK, input, 1 bit: the single system clock.
REQ-002 SHALL have port i_MRST_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port i_TICK, input, 1 bit: clock enable; state SHALL advance only on edges where i_TICK=1.
REQ-004 SHALL have port i_IFLAG, input, 10 bits: pending flags from the per-source flag registers (bit order INTT0,INTT1,INT1,INT2,INTE0,INTE1,INTEIN,INTAD,INTSR,INTST).
REQ-005 SHALL have port i_MASK, input, 10 bits: per-source mask, 1=masked, same bit order.
REQ-006 SHALL have port i_NMI_FLAG, input, 1 bit: NMI pending.
REQ-007 SHALL have port i_IE, input, 1 bit: global interrupt enable.
REQ-008 SHALL have port i_IRQ_ACK, input, 1 bit: core accepts the request and starts the service sequence.
REQ-009 SHALL have port o_IRQ_REQ, output, 1 bit: interrupt request to the core.
REQ-010 SHALL have port o_IRQ_VECTOR, output, 16 bits: service address.
REQ-011 SHALL have port o_IRQ_CODE, output, 5 bits: unique code of the winning source.
REQ-012 SHALL have port o_MULTI_EN, output, 10 bits: per source, 1 when both sources of its group are unmasked.
REQ-013 SHALL have port o_AUTO_ACK, output, 10 bits: one-tick clear pulse per source.
REQ-014 SHALL have port o_NMI_ACK, output, 1 bit: one-tick NMI clear pulse.

Function
REQ-015 Groups SHALL be fixed at NMI=0x0004, {INTT0,INTT1}=0x0008, {INT1,INT2}=0x0010, {INTE0,INTE1}=0x0018, {INTEIN,INTAD}=0x0020, {INTSR,INTST}=0x0028; the lower address SHALL have the higher priority.
REQ-016 A source SHALL be eligible when its flag=1, its mask=0 and i_IE=1; NMI SHALL be eligible whenever i_NMI_FLAG=1, regardless of i_IE.
REQ-017 Within a group, the lower bit index SHALL win.
REQ-018 Codes SHALL be NMI=0 and maskable source = bit index + 1.
REQ-019 o_MULTI_EN SHALL be combinational from i_MASK, with both bits of a group driven identically.
REQ-020 The FSM SHALL have three states: IDLE, PEND and ACK.
REQ-021 IDLE->PEND SHALL occur on the tick that any source is eligible; vector and code SHALL be latched on that tick, and o_IRQ_REQ SHALL be asserted from the next cycle (1-tick latency).
REQ-022 In PEND, vector and code SHALL stay frozen, except that a newly eligible NMI SHALL relatch NMI when i_IRQ_ACK=0.
REQ-023 In PEND with i_IRQ_ACK=1 -> ACK; i_IRQ_ACK in the same tick as NMI arrival SHALL keep the latched source.
REQ-024 In PEND, if the latched source is no longer eligible (flag cleared, masked, or i_IE=0) -> IDLE with no ack pulse.
REQ-025 In ACK, the FSM SHALL drop o_IRQ_REQ and return to IDLE after one tick.
REQ-026 In ACK, the FSM SHALL pulse o_AUTO_ACK[src] for one tick only when the group's o_MULTI_EN=0; otherwise no pulse (manual SKIT clear).
REQ-027 In ACK, the FSM SHALL pulse o_NMI_ACK when the latched source is NMI.
REQ-028 i_IRQ_ACK outside PEND SHALL be ignored.

Reset
REQ-029 i_MRST_n=0 SHALL, on the next i_EMUCLK edge regardless of i_TICK, force IDLE, o_IRQ_REQ=0, o_IRQ_VECTOR=0x0000, o_IRQ_CODE=0, o_AUTO_ACK=0, o_NMI_ACK=0.
REQ-030 Reset during PEND or ACK SHALL abort without any ack pulse.

Configuration
REQ-031 With macro IKA87AD_INTC_NMI_EN defined, NMI SHALL be arbitrated per REQ-016/022/027.
REQ-032 Without IKA87AD_INTC_NMI_EN, i_NMI_FLAG SHALL be ignored and o_NMI_ACK SHALL be tied 0, with ports unchanged.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the source bit-index constants, the 5-bit code constants and the group vector constants.
REQ-034 The combinational priority encoder (eligible vector -> index/code/vector) SHALL be one sub-module, ika87ad_intc_prienc.

Verification
REQ-035 i_IE=1, MASK=0x3FF except INT1 unmasked, IFLAG[2]=1 -> REQ after 1 tick, vector 0x0010, code 3; ACK -> one AUTO_ACK[2] pulse.
REQ-036 MASK bits 0,1 both 0, IFLAG[1]=1, ACK -> vector 0x0008, code 2, MULTI_EN[1:0]=11, no AUTO_ACK pulse.
REQ-037 IFLAG[9] and IFLAG[0] set simultaneously, all unmasked -> vector 0x0008, code 1.
REQ-038 PEND on INTAD, then NMI_FLAG=1 -> relatch 0x0004 code 0; ACK -> NMI_ACK pulse, no AUTO_ACK; macro undefined -> INTAD kept.
REQ-039 PEND, then i_IE=0 -> IDLE, REQ=0, no pulses.
REQ-040 Reset asserted during PEND -> all outputs 0 next edge; later ACK ignored.

Source files
------------

// File: rtl/ika87ad_intc_pkg.sv
// ika87ad_intc_pkg: shared FSM state, source indices, codes and group vectors for the interrupt controller
// Build option: define IKA87AD_INTC_NMI_EN to arbitrate NMI; otherwise NMI is ignored.
package ika87ad_intc_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_ACK} state_t;
  localparam int NSRC = 10;
  localparam logic [3:0] SRC_INTT0  = 4'd0;
  localparam logic [3:0] SRC_INTT1  = 4'd1;
  localparam logic [3:0] SRC_INT1   = 4'd2;
  localparam logic [3:0] SRC_INT2   = 4'd3;
  localparam logic [3:0] SRC_INTE0  = 4'd4;
  localparam logic [3:0] SRC_INTE1  = 4'd5;
  localparam logic [3:0] SRC_INTEIN = 4'd6;
  localparam logic [3:0] SRC_INTAD  = 4'd7;
  localparam logic [3:0] SRC_INTSR  = 4'd8;
  localparam logic [3:0] SRC_INTST  = 4'd9;
  localparam logic [4:0] CODE_NMI    = 5'd0;
  localparam logic [4:0] CODE_INTT0  = 5'd1;
  localparam logic [4:0] CODE_INTT1  = 5'd2;
  localparam logic [4:0] CODE_INT1   = 5'd3;
  localparam logic [4:0] CODE_INT2   = 5'd4;
  localparam logic [4:0] CODE_INTE0  = 5'd5;
  localparam logic [4:0] CODE_INTE1  = 5'd6;
  localparam logic [4:0] CODE_INTEIN = 5'd7;
  localparam logic [4:0] CODE_INTAD  = 5'd8;
  localparam logic [4:0] CODE_INTSR  = 5'd9;
  localparam logic [4:0] CODE_INTST  = 5'd10;
  localparam logic [15:0] VEC_NMI    = 16'h0004;
  localparam logic [15:0] VEC_TIMER  = 16'h0008;
  localparam logic [15:0] VEC_INT12  = 16'h0010;
  localparam logic [15:0] VEC_ECNT   = 16'h0018;
  localparam logic [15:0] VEC_EINAD  = 16'h0020;
  localparam logic [15:0] VEC_SERIAL = 16'h0028;
  // Sources are paired two per group, so the group is the index without its LSB.
  function automatic logic [15:0] group_vec(input logic [3:0] idx);
    case (idx[3:1])
      3'd0:    group_vec = VEC_TIMER;
      3'd1:    group_vec = VEC_INT12;
      3'd2:    group_vec = VEC_ECNT;
      3'd3:    group_vec = VEC_EINAD;
      default: group_vec = VEC_SERIAL;
    endcase
  endfunction
endpackage

// File: rtl/ika87ad_intc_if.sv
// ika87ad_intc_if: eligible-request bundle between the controller and its priority encoder
// master drives elig/nmi and reads the winner; slave (the encoder) does the reverse.
interface ika87ad_intc_if;
  logic [9:0]  elig;
  logic        nmi;
  logic        any;
  logic        is_nmi;
  logic [3:0]  idx;
  logic [4:0]  code;
  logic [15:0] vec;
  modport master (output elig, nmi, input any, is_nmi, idx, code, vec);
  modport slave (input elig, nmi, output any, is_nmi, idx, code, vec);
endinterface

// File: rtl/ika87ad_intc_prienc.sv
// ika87ad_intc_prienc: combinational priority encoder, eligible vector -> winning index/code/vector
// Port pe (slave): elig/nmi in; any, is_nmi, idx, code, vec out.
module ika87ad_intc_prienc
  import ika87ad_intc_pkg::*;
(
  ika87ad_intc_if.slave pe
);
  logic [3:0] idx;
  // Groups are ordered by address and bit order within groups, so the lowest set bit wins overall.
  always_comb begin
    idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) if (pe.elig[i]) idx = 4'(i);
  end
  assign pe.any    = pe.nmi | (|pe.elig);
  assign pe.is_nmi = pe.nmi;
  assign pe.idx    = idx;
  assign pe.code   = pe.nmi ? CODE_NMI : {1'b0, idx} + 5'd1;
  assign pe.vec    = pe.nmi ? VEC_NMI : group_vec(idx);
endmodule

// File: rtl/ika87ad_intc.sv
// ika87ad_intc: interrupt controller with grouped vectors, IDLE/PEND/ACK handshake and auto-clear pulses
// Ports: i_EMUCLK clock, i_MRST_n sync active-low reset, i_TICK clock enable, i_IFLAG/i_MASK per-source
// flags and masks, i_NMI_FLAG, i_IE, i_IRQ_ACK; o_IRQ_REQ/o_IRQ_VECTOR/o_IRQ_CODE request,
// o_MULTI_EN group-unmasked, o_AUTO_ACK/o_NMI_ACK one-tick clear pulses.
// Build option: IKA87AD_INTC_NMI_EN enables NMI arbitration; without it i_NMI_FLAG is ignored.
module ika87ad_intc
  import ika87ad_intc_pkg::*;
(
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_TICK,
  input  logic [9:0]  i_IFLAG,
  input  logic [9:0]  i_MASK,
  input  logic        i_NMI_FLAG,
  input  logic        i_IE,
  input  logic        i_IRQ_ACK,
  output logic        o_IRQ_REQ,
  output logic [15:0] o_IRQ_VECTOR,
  output logic [4:0]  o_IRQ_CODE,
  output logic [9:0]  o_MULTI_EN,
  output logic [9:0]  o_AUTO_ACK,
  output logic        o_NMI_ACK
);
  ika87ad_intc_if pe_if ();
  ika87ad_intc_prienc u_prienc (.pe(pe_if));
  state_t      state_q;
  logic        req_q, nmi_q, nmi_ack_q, nmi_elig, still_elig;
  logic [15:0] vec_q;
  logic [4:0]  code_q;
  logic [3:0]  idx_q;
  logic [9:0]  auto_q, elig, ack_vec;
`ifdef IKA87AD_INTC_NMI_EN
  assign nmi_elig = i_NMI_FLAG;
`else
  logic unused_nmi;
  assign unused_nmi = i_NMI_FLAG;
  assign nmi_elig   = 1'b0;
`endif
  assign elig        = i_IFLAG & ~i_MASK & {10{i_IE}};
  assign pe_if.elig  = elig;
  assign pe_if.nmi   = nmi_elig;
  for (genvar g = 0; g < 5; g++) begin : g_multi
    assign o_MULTI_EN[2*g +: 2] = {2{~|i_MASK[2*g +: 2]}};
  end
  assign still_elig = nmi_q ? nmi_elig : elig[idx_q];
  // A group with both sources enabled is cleared by software (SKIT), so no auto pulse there.
  assign ack_vec = (10'd1 << idx_q) & ~o_MULTI_EN;
  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      vec_q     <= '0;
      code_q    <= '0;
      idx_q     <= '0;
      nmi_q     <= 1'b0;
      auto_q    <= '0;
      nmi_ack_q <= 1'b0;
    end else if (i_TICK) begin
      auto_q    <= '0;
      nmi_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (pe_if.any) begin
          state_q <= ST_PEND;
          req_q   <= 1'b1;
          vec_q   <= pe_if.vec;
          code_q  <= pe_if.code;
          idx_q   <= pe_if.idx;
          nmi_q   <= pe_if.is_nmi;
        end
        ST_PEND: if (!still_elig) begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end else if (i_IRQ_ACK) begin
          state_q   <= ST_ACK;
          req_q     <= 1'b0;
          auto_q    <= nmi_q ? '0 : ack_vec;
          nmi_ack_q <= nmi_q;
        end else if (nmi_elig && !nmi_q) begin
          vec_q  <= VEC_NMI;
          code_q <= CODE_NMI;
          nmi_q  <= 1'b1;
        end
        ST_ACK: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign o_IRQ_REQ    = req_q;
  assign o_IRQ_VECTOR = vec_q;
  assign o_IRQ_CODE   = code_q;
  assign o_AUTO_ACK   = auto_q;
  assign o_NMI_ACK    = nmi_ack_q;
endmodule

// File: tb/tb_ika87ad_intc.sv
// tb_ika87ad_intc: table-driven and sequence checks of ika87ad_intc with an expectation queue
module tb_ika87ad_intc;
  typedef struct {
    logic [9:0]  iflag;
    logic [9:0]  mask;
    logic        ie;
    logic        req;
    logic [15:0] vec;
    logic [4:0]  code;
    logic [9:0]  multi;
    logic [9:0]  auto_ack;
  } vec_t;
  typedef struct {
    logic        vc;
    logic        req;
    logic [15:0] vec;
    logic [4:0]  code;
    logic [9:0]  multi;
    logic [9:0]  auto_ack;
    logic        nmi_ack;
  } exp_t;
  logic clk = 0, rst_n = 0, tick = 1, nmi = 0, ie = 0, ack = 0;
  logic [9:0] iflag = '0, mask = '0;
  logic        irq_req, nmi_ack;
  logic [15:0] irq_vec;
  logic [4:0]  irq_code;
  logic [9:0]  multi_en, auto_ack;
  int tests = 0, fails = 0;
  exp_t sb[$];
  vec_t tbl[9];
  always #5 clk = ~clk;
  ika87ad_intc dut (
    .i_EMUCLK(clk), .i_MRST_n(rst_n), .i_TICK(tick), .i_IFLAG(iflag), .i_MASK(mask),
    .i_NMI_FLAG(nmi), .i_IE(ie), .i_IRQ_ACK(ack), .o_IRQ_REQ(irq_req), .o_IRQ_VECTOR(irq_vec),
    .o_IRQ_CODE(irq_code), .o_MULTI_EN(multi_en), .o_AUTO_ACK(auto_ack), .o_NMI_ACK(nmi_ack)
  );
  ika87ad_intc_if pe_if ();
  ika87ad_intc_prienc u_pe (.pe(pe_if));
  function automatic logic [9:0] model_multi(input logic [9:0] m);
    logic [9:0] r;
    for (int g = 0; g < 5; g++) begin
      r[2*g]   = !(m[2*g] || m[2*g+1]);
      r[2*g+1] = r[2*g];
    end
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic push(input logic vc, input logic r, input logic [15:0] v, input logic [4:0] c,
                      input logic [9:0] a, input logic n);
    sb.push_back('{vc, r, v, c, model_multi(mask), a, n});
  endtask
  task automatic check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({nm, ".queue_empty"}, 16'd1, 16'd0);
      return;
    end
    e = sb.pop_front();
    cmp({nm, ".req"}, 16'(irq_req), 16'(e.req));
    if (e.vc) begin
      cmp({nm, ".vec"}, irq_vec, e.vec);
      cmp({nm, ".code"}, 16'(irq_code), 16'(e.code));
    end
    cmp({nm, ".multi"}, 16'(multi_en), 16'(e.multi));
    cmp({nm, ".auto"}, 16'(auto_ack), 16'(e.auto_ack));
    cmp({nm, ".nmi_ack"}, 16'(nmi_ack), 16'(e.nmi_ack));
  endtask
  task automatic do_reset();
    rst_n = 0; ack = 0; nmi = 0; iflag = '0;
    step();
    rst_n = 1;
  endtask
  initial begin
    tbl[0] = '{10'h004, 10'h3FB, 1'b1, 1'b1, 16'h0010, 5'd3,  10'h000, 10'h004};
    tbl[1] = '{10'h002, 10'h3FC, 1'b1, 1'b1, 16'h0008, 5'd2,  10'h003, 10'h000};
    tbl[2] = '{10'h201, 10'h000, 1'b1, 1'b1, 16'h0008, 5'd1,  10'h3FF, 10'h000};
    tbl[3] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 16'h0000, 5'd0,  10'h3FF, 10'h000};
    tbl[4] = '{10'h3FF, 10'h3FF, 1'b1, 1'b0, 16'h0000, 5'd0,  10'h000, 10'h000};
    tbl[5] = '{10'h200, 10'h1FF, 1'b1, 1'b1, 16'h0028, 5'd10, 10'h000, 10'h200};
    tbl[6] = '{10'h0C0, 10'h000, 1'b1, 1'b1, 16'h0020, 5'd7,  10'h3FF, 10'h000};
    tbl[7] = '{10'h020, 10'h3DF, 1'b1, 1'b1, 16'h0018, 5'd6,  10'h000, 10'h020};
    tbl[8] = '{10'h180, 10'h040, 1'b1, 1'b1, 16'h0020, 5'd8,  10'h33F, 10'h080};
    // reset state
    rst_n = 0;
    step();
    push(1, 0, 16'h0000, 5'd0, 10'h000, 0);
    check("reset");
    rst_n = 1;
    // table vectors: latch, ack, return to idle
    for (int k = 0; k < 9; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      do_reset();
      mask = tbl[k].mask; ie = tbl[k].ie; iflag = tbl[k].iflag;
      sb.push_back('{1'b1, tbl[k].req, tbl[k].vec, tbl[k].code, tbl[k].multi, 10'h000, 1'b0});
      step();
      check({nm, "_latch"});
      ack = 1;
      sb.push_back('{1'b1, 1'b0, tbl[k].vec, tbl[k].code, tbl[k].multi, tbl[k].auto_ack, 1'b0});
      step();
      check({nm, "_ack"});
      ack = 0; iflag = '0;
      push(0, 0, 16'h0000, 5'd0, 10'h000, 0);
      step();
      check({nm, "_idle"});
    end
    // NMI arriving while INTAD is pending
    do_reset();
    mask = '0; ie = 1; iflag = 10'h080;
    push(1, 1, 16'h0020, 5'd8, 10'h000, 0);
    step();
    check("nmi_pend");
    nmi = 1;
`ifdef IKA87AD_INTC_NMI_EN
    push(1, 1, 16'h0004, 5'd0, 10'h000, 0);
    step();
    check("nmi_relatch");
    ack = 1;
    push(1, 0, 16'h0004, 5'd0, 10'h000, 1);
    step();
    check("nmi_ack");
`else
    push(1, 1, 16'h0020, 5'd8, 10'h000, 0);
    step();
    check("nmi_ignored");
    ack = 1;
    push(1, 0, 16'h0020, 5'd8, 10'h000, 0);
    step();
    check("nmi_off_ack");
`endif
    ack = 0; nmi = 0; iflag = '0;
    push(0, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("nmi_done");
    // ack in the same tick as NMI arrival keeps the latched source
    do_reset();
    iflag = 10'h080;
    step();
    nmi = 1; ack = 1;
    push(1, 0, 16'h0020, 5'd8, 10'h000, 0);
    step();
    check("ack_with_nmi");
    nmi = 0; ack = 0; iflag = '0;
    step();
    // IE dropped while pending
    do_reset();
    mask = 10'h3FB; ie = 1; iflag = 10'h004;
    push(1, 1, 16'h0010, 5'd3, 10'h000, 0);
    step();
    check("ie_pend");
    ie = 0;
    push(0, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("ie_drop");
    ack = 1;
    push(0, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("ie_ack_ignored");
    ack = 0; ie = 1; iflag = '0;
    // reset while pending, later ack ignored
    do_reset();
    iflag = 10'h004;
    step();
    rst_n = 0;
    push(1, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("rst_in_pend");
    rst_n = 1; iflag = '0; ack = 1;
    push(1, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("rst_ack_ignored");
    ack = 0;
    // clock enable gating, and reset without a tick
    do_reset();
    iflag = 10'h004;
    step();
    tick = 0; rst_n = 0;
    push(1, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("rst_no_tick");
    rst_n = 1;
    push(1, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("no_tick_hold");
    tick = 1;
    push(1, 1, 16'h0010, 5'd3, 10'h000, 0);
    step();
    check("tick_latch");
    tick = 0; ack = 1;
    push(1, 1, 16'h0010, 5'd3, 10'h000, 0);
    step();
    check("tick_ack_held");
    tick = 1; ack = 0; iflag = '0;
    push(0, 0, 16'h0000, 5'd0, 10'h000, 0);
    step();
    check("flag_clear_idle");
    // priority encoder on its own
    pe_if.elig = 10'h300; pe_if.nmi = 0;
    #1;
    cmp("pe_st.code", 16'(pe_if.code), 16'd9);
    cmp("pe_st.vec", pe_if.vec, 16'h0028);
    pe_if.nmi = 1;
    #1;
    cmp("pe_nmi.code", 16'(pe_if.code), 16'd0);
    cmp("pe_nmi.vec", pe_if.vec, 16'h0004);
    pe_if.elig = '0; pe_if.nmi = 0;
    #1;
    cmp("pe_none.any", 16'(pe_if.any), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
